// File: rtl/fp_multiplier_seq.sv
// Multi-cycle floating-point multiplier: radix-2 shift-add significand product,
// round-to-nearest-even, subnormals flushed to zero, valid/ready on both sides.
module fp_multiplier_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] product,
   output logic                 infinity,
   output logic                 nan,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 inexact,
   output logic [2:0]           dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high; a producer holds valid and data until that edge, and the result side
   // keeps product/flags stable while out_valid is high and out_ready is low.

   localparam int SIG_W  = MAN_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int XE_W   = EXP_W + 2;
   localparam int CNT_W  = $clog2(MAN_W + 2);

   localparam logic [XE_W-1:0]  BIAS_X   = XE_W'((1 << (EXP_W - 1)) - 1);
   localparam logic [XE_W-1:0]  EMAX_X   = XE_W'((1 << EXP_W) - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_NORM = 3'd2,
      S_RND  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      C_NORMAL = 2'd0,
      C_NAN    = 2'd1,
      C_INF    = 2'd2,
      C_ZERO   = 2'd3
   } cls_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 sign_q, sign_d;
   logic [EXP_W-1:0]     ea_q, ea_d;
   logic [EXP_W-1:0]     eb_q, eb_d;
   cls_e                 cls_q, cls_d;
   logic [PROD_W-1:0]    mcand_q, mcand_d;
   logic [SIG_W-1:0]     mplier_q, mplier_d;
   logic [PROD_W-1:0]    acc_q, acc_d;
   logic [XE_W-1:0]      exp_q, exp_d;
   logic [MAN_W-1:0]     frac_q, frac_d;
   logic                 guard_q, guard_d;
   logic                 sticky_q, sticky_d;
   logic                 out_valid_q, out_valid_d;
   logic [EXP_W+MAN_W:0] product_q, product_d;
   logic                 infinity_q, infinity_d;
   logic                 nan_q, nan_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;
   logic                 inexact_q, inexact_d;

   logic                 sa, sb;
   logic [EXP_W-1:0]     ea_in, eb_in;
   logic [MAN_W-1:0]     fa_in, fb_in;
   logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   cls_e                 cls_in;

   logic [PROD_W-1:0]    norm_w;
   logic [XE_W-1:0]      exp_norm;
   logic                 round_up, carry;
   logic [MAN_W-1:0]     frac_r;
   logic [XE_W-1:0]      exp_r;

   logic [EXP_W+MAN_W:0] res_product;
   logic                 res_inf, res_nan, res_ovf, res_unf, res_inx;

   assign {sa, ea_in, fa_in} = a;
   assign {sb, eb_in, fb_in} = b;

   // Special-case class is decided once at accept; the datapath still runs so
   // every operation takes the same number of cycles.
   always_comb begin
      a_nan  = (&ea_in) && (fa_in != '0);
      b_nan  = (&eb_in) && (fb_in != '0);
      a_inf  = (&ea_in) && (fa_in == '0);
      b_inf  = (&eb_in) && (fb_in == '0);
      a_zero = (ea_in == '0);
      b_zero = (eb_in == '0);
      cls_in = C_NORMAL;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         cls_in = C_NAN;
      end else if (a_inf || b_inf) begin
         cls_in = C_INF;
      end else if (a_zero || b_zero) begin
         cls_in = C_ZERO;
      end
   end

   always_comb begin
      norm_w   = acc_q[PROD_W-1] ? acc_q : (acc_q << 1);
      exp_norm = {2'b00, ea_q} + {2'b00, eb_q} - BIAS_X + XE_W'(acc_q[PROD_W-1]);
      round_up = guard_q & (sticky_q | frac_q[0]);
      {carry, frac_r} = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_up};
      exp_r    = exp_q + {{(XE_W-1){1'b0}}, carry};
   end

   // Exponent is two's complement in XE_W bits, so the top bit marks <= -1.
   always_comb begin
      res_product = {sign_q, exp_r[EXP_W-1:0], frac_r};
      res_inf     = 1'b0;
      res_nan     = 1'b0;
      res_ovf     = 1'b0;
      res_unf     = 1'b0;
      res_inx     = guard_q | sticky_q;
      if (cls_q == C_NAN) begin
         res_product = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         res_nan     = 1'b1;
         res_inx     = 1'b0;
      end else if (cls_q == C_INF) begin
         res_product = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         res_inf     = 1'b1;
         res_inx     = 1'b0;
      end else if (cls_q == C_ZERO) begin
         res_product = {sign_q, {(EXP_W+MAN_W){1'b0}}};
         res_inx     = 1'b0;
      end else if (!exp_r[XE_W-1] && (exp_r >= EMAX_X)) begin
         res_product = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         res_inf     = 1'b1;
         res_ovf     = 1'b1;
         res_inx     = 1'b1;
      end else if (exp_r[XE_W-1] || (exp_r == '0)) begin
         res_product = {sign_q, {(EXP_W+MAN_W){1'b0}}};
         res_unf     = 1'b1;
         res_inx     = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      ea_d        = ea_q;
      eb_d        = eb_q;
      cls_d       = cls_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      exp_d       = exp_q;
      frac_d      = frac_q;
      guard_d     = guard_q;
      sticky_d    = sticky_q;
      out_valid_d = out_valid_q;
      product_d   = product_q;
      infinity_d  = infinity_q;
      nan_d       = nan_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      inexact_d   = inexact_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_d   = sa ^ sb;
               ea_d     = ea_in;
               eb_d     = eb_in;
               cls_d    = cls_in;
               mcand_d  = {{SIG_W{1'b0}}, 1'b1, fa_in};
               mplier_d = {1'b1, fb_in};
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_NORM;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_NORM: begin
            exp_d    = exp_norm;
            frac_d   = norm_w[PROD_W-2 -: MAN_W];
            guard_d  = norm_w[PROD_W-2-MAN_W];
            sticky_d = |norm_w[PROD_W-3-MAN_W:0];
            state_d  = S_RND;
         end
         S_RND: begin
            product_d   = res_product;
            infinity_d  = res_inf;
            nan_d       = res_nan;
            overflow_d  = res_ovf;
            underflow_d = res_unf;
            inexact_d   = res_inx;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         ea_q        <= '0;
         eb_q        <= '0;
         cls_q       <= C_NORMAL;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         exp_q       <= '0;
         frac_q      <= '0;
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
         out_valid_q <= 1'b0;
         product_q   <= '0;
         infinity_q  <= 1'b0;
         nan_q       <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         inexact_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         ea_q        <= ea_d;
         eb_q        <= eb_d;
         cls_q       <= cls_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         exp_q       <= exp_d;
         frac_q      <= frac_d;
         guard_q     <= guard_d;
         sticky_q    <= sticky_d;
         out_valid_q <= out_valid_d;
         product_q   <= product_d;
         infinity_q  <= infinity_d;
         nan_q       <= nan_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         inexact_q   <= inexact_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign infinity  = infinity_q;
   assign nan       = nan_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign inexact   = inexact_q;
   assign dbg_state = state_q;

endmodule
